// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared constants, drain FSM states and size clamp for the PE array drain
package pe_array_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ARRAY_DIM  = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_LOW = 2'd2
  } drain_state_t;

  // Oversized requests saturate to the physical array; 0 passes through so the caller can flag it.
  function automatic logic [2:0] clamp_size(input logic [2:0] fs);
    if (fs > 3'(ARRAY_DIM)) begin
      return 3'(ARRAY_DIM);
    end
    return fs;
  endfunction

endpackage

// File: rtl/pe_array_result_drain_if.sv
// rtl/pe_array_result_drain_if.sv - result stream from the drain to the downstream writer
interface pe_array_result_drain_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [2:0]            out_row;
  logic [2:0]            out_col;
  logic                  out_last;

  modport master (
    output out_data, out_valid, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_row, out_col, out_last,
    output out_ready
  );

endinterface

// File: rtl/pe_drain_index_ctr.sv
// rtl/pe_drain_index_ctr.sv - row-major row/col walker over an N x N sub-block
module pe_drain_index_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  input  logic [2:0] n,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == n - 3'd1);
  assign row_end = (row == n - 3'd1);
  assign last    = col_end && row_end;

  // Advancing past the final element wraps back to (0,0) so the walker is ready for the next block.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row <= 3'd0;
      col <= 3'd0;
    end else if (advance) begin
      if (col_end) begin
        col <= 3'd0;
        row <= row_end ? 3'd0 : row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/pe_array_result_drain.sv
// rtl/pe_array_result_drain.sv - snapshots PE array results on done and streams the N x N block
module pe_array_result_drain #(
  parameter int DATA_WIDTH = pe_array_pkg::DATA_WIDTH,
  parameter int ARRAY_DIM  = pe_array_pkg::ARRAY_DIM
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     done,
  input  logic [2:0]                               filter_size,
  input  logic [ARRAY_DIM*ARRAY_DIM*DATA_WIDTH-1:0] pe_out,
  pe_array_result_drain_if.master                  drain,
  output logic                                     busy,
  output logic                                     size_err,
  output logic                                     overrun
);

  import pe_array_pkg::*;

  localparam int NWORDS = ARRAY_DIM * ARRAY_DIM;
  localparam int IW     = $clog2(NWORDS);

  drain_state_t          state;
  drain_state_t          state_nx;
  logic                  done_q;
  logic                  done_rise;
  logic                  load;
  logic                  xfer;
  logic                  last;
  logic [2:0]            n_cap;
  logic [2:0]            n_q;
  logic [2:0]            row;
  logic [2:0]            col;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] snap [NWORDS];

  assign done_rise = done & ~done_q;
  assign n_cap     = clamp_size(filter_size);
  assign load      = (state == IDLE) && done_rise;
  assign xfer      = (state == STREAM) && drain.out_ready;
  assign idx       = IW'(row) * IW'(ARRAY_DIM) + IW'(col);

  pe_drain_index_ctr u_idx (
    .clk     (clk),
    .reset   (reset),
    .clear   (load),
    .advance (xfer),
    .n       (n_q),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      n_q      <= 3'd0;
      size_err <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nx;
      done_q   <= done;
      size_err <= load && (n_cap == 3'd0);
      if (load) begin
        n_q <= n_cap;
      end
      if (done_rise && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  // The bank is deliberately left out of reset: it is only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NWORDS; i++) begin
        snap[i] <= pe_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (done_rise) begin
          state_nx = (n_cap == 3'd0) ? WAIT_LOW : STREAM;
        end
      end
      STREAM: begin
        if (xfer && last) begin
          state_nx = done ? WAIT_LOW : IDLE;
        end
      end
      WAIT_LOW: begin
        if (!done) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign drain.out_valid = (state == STREAM);
  assign drain.out_data  = drain.out_valid ? snap[idx] : '0;
  assign drain.out_row   = row;
  assign drain.out_col   = col;
  assign drain.out_last  = drain.out_valid && last;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_pe_array_result_drain.sv
// tb/tb_pe_array_result_drain.sv - randomized bench for pe_array_result_drain against a beat-queue model
module tb_pe_array_result_drain;

  localparam int DW = 16;
  localparam int AD = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              done;
  logic [2:0]        filter_size;
  logic [AD*AD*DW-1:0] pe_out;
  logic              busy;
  logic              size_err;
  logic              overrun;

  pe_array_result_drain_if #(.DATA_WIDTH(DW)) sif ();

  pe_array_result_drain #(.DATA_WIDTH(DW), .ARRAY_DIM(AD)) dut (
    .clk         (clk),
    .reset       (reset),
    .done        (done),
    .filter_size (filter_size),
    .pe_out      (pe_out),
    .drain       (sif),
    .busy        (busy),
    .size_err    (size_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            r;
    int            c;
    bit            last;
  } beat_t;

  beat_t q[$];
  bit    m_need_low;
  bit    m_prev_done;
  bit    m_ovr;
  bit    m_serr;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff_size(input logic [2:0] fs);
    return (fs > 3'd5) ? 5 : int'(fs);
  endfunction

  // Predict what the next rising edge does, from the inputs currently driven.
  task automatic model_edge();
    bit    idle_b;
    bit    rise;
    int    n;
    beat_t b;
    if (reset) begin
      q.delete();
      m_need_low  = 0;
      m_prev_done = 0;
      m_ovr       = 0;
      m_serr      = 0;
      return;
    end
    idle_b = (q.size() == 0) && !m_need_low;
    rise   = done && !m_prev_done;
    m_serr = 0;
    if (m_need_low && !done) m_need_low = 0;
    if (q.size() > 0 && sif.out_ready) begin
      b = q.pop_front();
      if (b.last && done) m_need_low = 1;
    end
    if (rise && !idle_b) m_ovr = 1;
    if (rise && idle_b) begin
      n = eff_size(filter_size);
      if (n == 0) begin
        m_serr     = 1;
        m_need_low = 1;
      end else begin
        for (int r = 0; r < n; r++) begin
          for (int c = 0; c < n; c++) begin
            b.d    = pe_out[(r*AD+c)*DW +: DW];
            b.r    = r;
            b.c    = c;
            b.last = (r == n-1) && (c == n-1);
            q.push_back(b);
          end
        end
      end
    end
    m_prev_done = done;
  endtask

  task automatic check_outputs(input bit was_reset);
    check_eq("out_valid", 32'(sif.out_valid), 32'(q.size() > 0));
    check_eq("busy", 32'(busy), 32'((q.size() > 0) || m_need_low));
    check_eq("size_err", 32'(size_err), 32'(m_serr));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    if (q.size() > 0) begin
      check_eq("out_data", 32'(sif.out_data), 32'(q[0].d));
      check_eq("out_row", 32'(sif.out_row), 32'(q[0].r));
      check_eq("out_col", 32'(sif.out_col), 32'(q[0].c));
      check_eq("out_last", 32'(sif.out_last), 32'(q[0].last));
    end
    if (was_reset) begin
      check_eq("rst_data", 32'(sif.out_data), 32'h0);
      check_eq("rst_row", 32'(sif.out_row), 32'h0);
      check_eq("rst_col", 32'(sif.out_col), 32'h0);
      check_eq("rst_last", 32'(sif.out_last), 32'h0);
    end
  endtask

  task automatic cyc(input bit rst, input bit d, input bit rdy);
    reset         = rst;
    done          = d;
    sif.out_ready = rdy;
    model_edge();
    @(negedge clk);
    check_outputs(rst);
  endtask

  task automatic load_ramp(input logic [DW-1:0] base);
    for (int i = 0; i < AD*AD; i++) pe_out[i*DW +: DW] = base + DW'(i);
  endtask

  task automatic load_random();
    for (int i = 0; i < AD*AD; i++) pe_out[i*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    reset         = 1'b1;
    done          = 1'b0;
    filter_size   = 3'd5;
    pe_out        = '0;
    sif.out_ready = 1'b1;
    m_need_low    = 0;
    m_prev_done   = 0;
    m_ovr         = 0;
    m_serr        = 0;

    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(0, 0, 1);

    // N=5 ramp at full rate
    load_ramp(16'h3C00);
    filter_size = 3'd5;
    cyc(0, 0, 1);
    for (int i = 0; i < 27; i++) cyc(0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);

    // N=3 with alternating ready
    load_random();
    filter_size = 3'd3;
    for (int i = 0; i < 24; i++) cyc(0, 1, (i % 2) == 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1);

    // snapshot isolation: inputs scrambled right after capture
    load_ramp(16'hC000);
    filter_size = 3'd5;
    cyc(0, 1, 1);
    pe_out      = '0;
    filter_size = 3'd2;
    for (int i = 0; i < 28; i++) cyc(0, 1, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1);

    // held-high done must not retrigger; a fresh rise restarts
    load_random();
    filter_size = 3'd2;
    for (int i = 0; i < 20; i++) cyc(0, 1, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1);
    load_random();
    for (int i = 0; i < 10; i++) cyc(0, 1, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1);

    // size 0 error, size 7 clamp, re-rise mid-stream
    filter_size = 3'd0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1);
    load_random();
    filter_size = 3'd7;
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 26; i++) cyc(0, 1, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1);

    // reset in the middle of a stream
    load_random();
    filter_size = 3'd5;
    for (int i = 0; i < 11; i++) cyc(0, 1, 1);
    cyc(1, 0, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1);
    load_random();
    for (int i = 0; i < 27; i++) cyc(0, 1, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1);

    // random traffic
    begin
      bit d = 0;
      for (int i = 0; i < 500; i++) begin
        if (($urandom % 8) == 0) d = !d;
        filter_size = 3'($urandom);
        load_random();
        cyc(($urandom % 120) == 0, d, ($urandom % 4) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
